// File: rtl/cic_decim_mc.sv
// cic_decim_mc: multi-channel, runtime-rate CIC decimator for complex baseband.
// CHANNELS independent I/Q pairs share one decimation counter. The path is an
// input register, then STAGES pipelined integrators, then STAGES registered
// combs, then an output shift/saturate register.
// Optional feature macro: CIC_DECIM_ROUND_EN. When defined, the output is
// rounded half up before the shift; otherwise it is truncated (floor).
module cic_decim_mc #(
  parameter int IN_WIDTH       = 16,
  parameter int OUT_WIDTH      = 24,
  parameter int CHANNELS       = 2,
  parameter int STAGES         = 5,
  parameter int DELAY          = 2,
  parameter int MAX_FACTOR     = 512,
  parameter int DEFAULT_FACTOR = 313
) (
  input  logic                                                         i_clock,
  input  logic                                                         i_reset,
  input  logic [CHANNELS*IN_WIDTH-1:0]                                 i_inph_data,
  input  logic [CHANNELS*IN_WIDTH-1:0]                                 i_quad_data,
  input  logic                                                         i_valid,
  input  logic [$clog2(MAX_FACTOR+1)-1:0]                              i_rate,
  input  logic                                                         i_rate_load,
  input  logic [$clog2(IN_WIDTH+STAGES*$clog2(MAX_FACTOR*DELAY))-1:0] i_shift,
  output logic [CHANNELS*OUT_WIDTH-1:0]                                o_inph_data,
  output logic [CHANNELS*OUT_WIDTH-1:0]                                o_quad_data,
  output logic                                                         o_valid
);

  localparam int ACC_WIDTH   = IN_WIDTH + STAGES*$clog2(MAX_FACTOR*DELAY);
  localparam int RATE_W      = $clog2(MAX_FACTOR+1);
  localparam int SHIFT_W     = $clog2(ACC_WIDTH);
  localparam int LANES       = 2*CHANNELS;
  localparam int PRIME_COUNT = STAGES*DELAY;
  localparam int PRIME_W     = $clog2(PRIME_COUNT+1);
  localparam int SUM_W       = ACC_WIDTH + 1;

  typedef logic signed [ACC_WIDTH-1:0] acc_t;
  typedef logic signed [SUM_W-1:0]     sum_t;
  typedef logic signed [OUT_WIDTH-1:0] out_t;

  localparam sum_t OUT_MAX_S = {{(SUM_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam sum_t OUT_MIN_S = {{(SUM_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  localparam out_t OUT_MAX   = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam out_t OUT_MIN   = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  // Rate and decimation control
  logic [RATE_W-1:0]  rate_q, rate_d, decCnt_q, decCnt_d, rateLoadVal;
  logic               inVld_q, inVld_d, inStb_q, inStb_d;

  // Input register, one entry per lane (I lanes first, then Q lanes)
  acc_t               laneIn   [LANES];
  acc_t               inData_q [LANES];
  acc_t               inData_d [LANES];

  // Integrator cascade
  acc_t               integ_q  [LANES][STAGES];
  acc_t               integ_d  [LANES][STAGES];
  acc_t               intSrc   [LANES][STAGES];
  logic [STAGES-1:0]  intVld_q, intVld_d, intStb_q, intStb_d, intVldIn, intStbIn;

  // Comb cascade
  acc_t               comb_q    [LANES][STAGES];
  acc_t               comb_d    [LANES][STAGES];
  acc_t               combSrc   [LANES][STAGES];
  acc_t               combDly_q [LANES][STAGES][DELAY];
  acc_t               combDly_d [LANES][STAGES][DELAY];
  logic [STAGES-1:0]  combVld_q, combVld_d, combVldIn;

  // Output stage
  sum_t               sumLane   [LANES];
  sum_t               shLane    [LANES];
  out_t               satLane   [LANES];
  out_t               outData_q [LANES];
  out_t               outData_d [LANES];
  logic [PRIME_W-1:0] primeCnt_q, primeCnt_d;
  logic               oValid_q, oValid_d;
  logic               primed;
`ifdef CIC_DECIM_ROUND_EN
  sum_t               roundAdd;
`endif

  // Clamp a requested rate into the legal range 1..MAX_FACTOR
  always_comb begin
    rateLoadVal = i_rate;
    if (i_rate == '0) begin
      rateLoadVal = RATE_W'(1);
    end else if (i_rate > RATE_W'(MAX_FACTOR)) begin
      rateLoadVal = RATE_W'(MAX_FACTOR);
    end
  end

  // Decimation counter: tag sample R-1 of each block as the strobe
  always_comb begin
    rate_d   = rate_q;
    decCnt_d = decCnt_q;
    inVld_d  = 1'b0;
    inStb_d  = 1'b0;
    if (i_rate_load) begin
      rate_d   = rateLoadVal;
      decCnt_d = '0;
    end else if (i_valid) begin
      inVld_d = 1'b1;
      if (decCnt_q == rate_q - RATE_W'(1)) begin
        decCnt_d = '0;
        inStb_d  = 1'b1;
      end else begin
        decCnt_d = decCnt_q + RATE_W'(1);
      end
    end
  end

  // Unpack and sign-extend the I and Q inputs into lanes
  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      laneIn[c]          = acc_t'($signed(i_inph_data[c*IN_WIDTH +: IN_WIDTH]));
      laneIn[c+CHANNELS] = acc_t'($signed(i_quad_data[c*IN_WIDTH +: IN_WIDTH]));
    end
  end

  // Input register captures accepted samples; a rate load flushes it
  always_comb begin
    inData_d = inData_q;
    if (i_rate_load) begin
      inData_d = '{default: '0};
    end else if (i_valid) begin
      inData_d = laneIn;
    end
  end

  // Wire each integrator stage to the output of the stage before it
  always_comb begin
    intVldIn[0] = inVld_q;
    intStbIn[0] = inStb_q;
    for (int s = 1; s < STAGES; s++) begin
      intVldIn[s] = intVld_q[s-1];
      intStbIn[s] = intStb_q[s-1];
    end
    for (int l = 0; l < LANES; l++) begin
      intSrc[l][0] = inData_q[l];
      for (int s = 1; s < STAGES; s++) begin
        intSrc[l][s] = integ_q[l][s-1];
      end
    end
  end

  // Integrators accumulate only when their stage-valid is set
  always_comb begin
    integ_d  = integ_q;
    intVld_d = '0;
    intStb_d = '0;
    if (i_rate_load) begin
      integ_d = '{default: '0};
    end else begin
      intVld_d = intVldIn;
      intStb_d = intStbIn;
      for (int l = 0; l < LANES; l++) begin
        for (int s = 0; s < STAGES; s++) begin
          if (intVldIn[s]) begin
            integ_d[l][s] = integ_q[l][s] + intSrc[l][s];
          end
        end
      end
    end
  end

  // Wire each comb stage to the stage before it; the first one sees strobed integrator output
  always_comb begin
    combVldIn[0] = intVld_q[STAGES-1] & intStb_q[STAGES-1];
    for (int k = 1; k < STAGES; k++) begin
      combVldIn[k] = combVld_q[k-1];
    end
    for (int l = 0; l < LANES; l++) begin
      combSrc[l][0] = integ_q[l][STAGES-1];
      for (int k = 1; k < STAGES; k++) begin
        combSrc[l][k] = comb_q[l][k-1];
      end
    end
  end

  // Combs y = x - x[n-DELAY]; delay lines advance only on strobe-valid
  always_comb begin
    comb_d    = comb_q;
    combDly_d = combDly_q;
    combVld_d = '0;
    if (i_rate_load) begin
      comb_d    = '{default: '0};
      combDly_d = '{default: '0};
    end else begin
      combVld_d = combVldIn;
      for (int l = 0; l < LANES; l++) begin
        for (int k = 0; k < STAGES; k++) begin
          if (combVldIn[k]) begin
            comb_d[l][k]       = combSrc[l][k] - combDly_q[l][k][DELAY-1];
            combDly_d[l][k][0] = combSrc[l][k];
            for (int j = 1; j < DELAY; j++) begin
              combDly_d[l][k][j] = combDly_q[l][k][j-1];
            end
          end
        end
      end
    end
  end

  // Scale the last comb output by i_shift, then clip to the signed output range
  always_comb begin
`ifdef CIC_DECIM_ROUND_EN
    roundAdd = '0;
    if (i_shift != '0) begin
      roundAdd = sum_t'(1) << (i_shift - SHIFT_W'(1));
    end
`endif
    for (int l = 0; l < LANES; l++) begin
`ifdef CIC_DECIM_ROUND_EN
      sumLane[l] = sum_t'(comb_q[l][STAGES-1]) + roundAdd;
`else
      sumLane[l] = sum_t'(comb_q[l][STAGES-1]);
`endif
      shLane[l] = sumLane[l] >>> i_shift;
      if (shLane[l] > OUT_MAX_S) begin
        satLane[l] = OUT_MAX;
      end else if (shLane[l] < OUT_MIN_S) begin
        satLane[l] = OUT_MIN;
      end else begin
        satLane[l] = shLane[l][OUT_WIDTH-1:0];
      end
    end
  end

  // Suppress the first STAGES*DELAY results after a restart, then emit each result
  always_comb begin
    primed     = (primeCnt_q == PRIME_W'(PRIME_COUNT));
    primeCnt_d = primeCnt_q;
    oValid_d   = 1'b0;
    outData_d  = outData_q;
    if (i_rate_load) begin
      primeCnt_d = '0;
    end else if (combVld_q[STAGES-1]) begin
      if (!primed) begin
        primeCnt_d = primeCnt_q + PRIME_W'(1);
      end else begin
        oValid_d  = 1'b1;
        outData_d = satLane;
      end
    end
  end

  // State register with synchronous reset
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      rate_q     <= RATE_W'(DEFAULT_FACTOR);
      decCnt_q   <= '0;
      inVld_q    <= 1'b0;
      inStb_q    <= 1'b0;
      inData_q   <= '{default: '0};
      integ_q    <= '{default: '0};
      intVld_q   <= '0;
      intStb_q   <= '0;
      comb_q     <= '{default: '0};
      combDly_q  <= '{default: '0};
      combVld_q  <= '0;
      primeCnt_q <= '0;
      oValid_q   <= 1'b0;
      outData_q  <= '{default: '0};
    end else begin
      rate_q     <= rate_d;
      decCnt_q   <= decCnt_d;
      inVld_q    <= inVld_d;
      inStb_q    <= inStb_d;
      inData_q   <= inData_d;
      integ_q    <= integ_d;
      intVld_q   <= intVld_d;
      intStb_q   <= intStb_d;
      comb_q     <= comb_d;
      combDly_q  <= combDly_d;
      combVld_q  <= combVld_d;
      primeCnt_q <= primeCnt_d;
      oValid_q   <= oValid_d;
      outData_q  <= outData_d;
    end
  end

  // Pack the lane output registers onto the I and Q output buses
  always_comb begin
    o_inph_data = '0;
    o_quad_data = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      o_inph_data[c*OUT_WIDTH +: OUT_WIDTH] = outData_q[c];
      o_quad_data[c*OUT_WIDTH +: OUT_WIDTH] = outData_q[c+CHANNELS];
    end
  end

  assign o_valid = oValid_q;

endmodule

// File: tb/tb_cic_decim_mc.sv
// tb_cic_decim_mc: directed self-checking bench for cic_decim_mc.
// Instance: STAGES=3, DELAY=1, CHANNELS=2, OUT_WIDTH=24. With R=8 the DC gain
// is 8^3 = 2^9, so shift 9 returns the input value unchanged.
module tb_cic_decim_mc;

  localparam int IN_WIDTH       = 16;
  localparam int OUT_WIDTH      = 24;
  localparam int CHANNELS       = 2;
  localparam int STAGES         = 3;
  localparam int DELAY          = 1;
  localparam int MAX_FACTOR     = 512;
  localparam int DEFAULT_FACTOR = 313;
  localparam int ACC_WIDTH      = IN_WIDTH + STAGES*$clog2(MAX_FACTOR*DELAY);
  localparam int RATE_W         = $clog2(MAX_FACTOR+1);
  localparam int SHIFT_W        = $clog2(ACC_WIDTH);
  localparam int PRIME          = STAGES*DELAY;
  localparam int LATENCY        = 2*STAGES+1;
  localparam int OW             = CHANNELS*OUT_WIDTH;

  logic                         i_clock = 1'b0;
  logic                         i_reset;
  logic [CHANNELS*IN_WIDTH-1:0] i_inph_data;
  logic [CHANNELS*IN_WIDTH-1:0] i_quad_data;
  logic                         i_valid;
  logic [RATE_W-1:0]            i_rate;
  logic                         i_rate_load;
  logic [SHIFT_W-1:0]           i_shift;
  logic [OW-1:0]                o_inph_data;
  logic [OW-1:0]                o_quad_data;
  logic                         o_valid;

  cic_decim_mc #(
    .IN_WIDTH(IN_WIDTH), .OUT_WIDTH(OUT_WIDTH), .CHANNELS(CHANNELS),
    .STAGES(STAGES), .DELAY(DELAY), .MAX_FACTOR(MAX_FACTOR),
    .DEFAULT_FACTOR(DEFAULT_FACTOR)
  ) dut (
    .i_clock(i_clock), .i_reset(i_reset),
    .i_inph_data(i_inph_data), .i_quad_data(i_quad_data),
    .i_valid(i_valid), .i_rate(i_rate), .i_rate_load(i_rate_load),
    .i_shift(i_shift),
    .o_inph_data(o_inph_data), .o_quad_data(o_quad_data), .o_valid(o_valid)
  );

  always #5 i_clock = ~i_clock;

  int vectors     = 0;
  int miscompares = 0;
  int edgeCnt     = 0;
  int modelCnt    = 0;
  int modelRate   = DEFAULT_FACTOR;
  int strobeEdges[$];
  int pulseEdges[$];
  logic [OW-1:0] pulseI[$];
  logic [OW-1:0] pulseQ[$];

  function automatic logic [OW-1:0] pack2(input int a0, input int a1);
    logic [OW-1:0] r;
    r[0 +: OUT_WIDTH]         = a0[OUT_WIDTH-1:0];
    r[OUT_WIDTH +: OUT_WIDTH] = a1[OUT_WIDTH-1:0];
    return r;
  endfunction

  task automatic setData(input int i0, input int q0, input int i1, input int q1);
    i_inph_data = {IN_WIDTH'(i1), IN_WIDTH'(i0)};
    i_quad_data = {IN_WIDTH'(q1), IN_WIDTH'(q0)};
  endtask

  // One clock: drive, advance the block-position model, then log any output pulse
  task automatic tick(input logic v, input logic ld);
    i_valid     = v;
    i_rate_load = ld;
    @(posedge i_clock);
    edgeCnt++;
    if (i_reset) begin
      modelCnt  = 0;
      modelRate = DEFAULT_FACTOR;
      strobeEdges.delete();
    end else if (ld) begin
      modelCnt = 0;
      strobeEdges.delete();
      if (i_rate == '0) modelRate = 1;
      else if (int'(i_rate) > MAX_FACTOR) modelRate = MAX_FACTOR;
      else modelRate = int'(i_rate);
    end else if (v) begin
      modelCnt++;
      if (modelCnt >= modelRate) begin
        modelCnt = 0;
        strobeEdges.push_back(edgeCnt);
      end
    end
    #1;
    if (o_valid === 1'b1) begin
      pulseEdges.push_back(edgeCnt);
      pulseI.push_back(o_inph_data);
      pulseQ.push_back(o_quad_data);
    end
  endtask

  task automatic clearCapture();
    pulseEdges.delete();
    pulseI.delete();
    pulseQ.delete();
  endtask

  task automatic loadRate(input int r, input int sh);
    i_rate  = RATE_W'(r);
    i_shift = SHIFT_W'(sh);
    tick(1'b0, 1'b1);
  endtask

  task automatic test_reset();
    setData(123, -45, 678, -9);
    i_reset = 1'b1;
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    vectors++;
    if (o_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b, expected 0", o_valid); end
    vectors++;
    if (o_inph_data !== '0) begin miscompares++; $display("[TB] FAIL reset_inph: got %h, expected 0", o_inph_data); end
    vectors++;
    if (o_quad_data !== '0) begin miscompares++; $display("[TB] FAIL reset_quad: got %h, expected 0", o_quad_data); end
    i_reset = 1'b0;
  endtask

  task automatic test_idle();
    clearCapture();
    setData(1000, -1000, 0, 0);
    for (int i = 0; i < 1000; i++) tick(1'b0, 1'b0);
    vectors++;
    if (pulseEdges.size() != 0) begin miscompares++; $display("[TB] FAIL idle_pulses: got %0d, expected 0", pulseEdges.size()); end
    vectors++;
    if (o_inph_data !== '0 || o_quad_data !== '0) begin
      miscompares++; $display("[TB] FAIL idle_data: got %h/%h, expected 0/0", o_inph_data, o_quad_data);
    end
  endtask

  task automatic test_dc_gain();
    logic [OW-1:0] expI, expQ;
    int expEdge;
    expI = pack2(1000, 0);
    expQ = pack2(-1000, 0);
    setData(1000, -1000, 0, 0);
    loadRate(8, 9);
    clearCapture();
    for (int i = 0; i < 1600; i++) tick((i % 2) == 0, 1'b0);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b0);
    vectors++;
    if (pulseEdges.size() != 97) begin miscompares++; $display("[TB] FAIL dc_count: got %0d pulses, expected 97", pulseEdges.size()); end
    foreach (pulseEdges[p]) begin
      expEdge = (p + PRIME < strobeEdges.size()) ? strobeEdges[p+PRIME] + LATENCY : -1;
      vectors++;
      if (pulseEdges[p] != expEdge) begin miscompares++; $display("[TB] FAIL dc_latency[%0d]: got edge %0d, expected %0d", p, pulseEdges[p], expEdge); end
      vectors++;
      if (pulseI[p] !== expI) begin miscompares++; $display("[TB] FAIL dc_inph[%0d]: got %h, expected %h", p, pulseI[p], expI); end
      vectors++;
      if (pulseQ[p] !== expQ) begin miscompares++; $display("[TB] FAIL dc_quad[%0d]: got %h, expected %h", p, pulseQ[p], expQ); end
    end
  endtask

  task automatic test_rate_reload();
    logic [OW-1:0] expI, expQ;
    int expEdge;
    expI = pack2(1000, 0);
    expQ = pack2(-1000, 0);
    setData(1000, -1000, 0, 0);
    clearCapture();
    for (int i = 0; i < 8; i++) tick(1'b1, 1'b0);
    i_rate  = RATE_W'(16);
    i_shift = SHIFT_W'(12);
    tick(1'b1, 1'b1);
    vectors++;
    if (o_valid !== 1'b0 || o_inph_data !== expI) begin
      miscompares++; $display("[TB] FAIL reload_hold: got valid %b data %h, expected 0 / %h", o_valid, o_inph_data, expI);
    end
    clearCapture();
    for (int i = 0; i < 96; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);
    vectors++;
    if (pulseEdges.size() != 3) begin miscompares++; $display("[TB] FAIL reload_count: got %0d pulses, expected 3", pulseEdges.size()); end
    foreach (pulseEdges[p]) begin
      expEdge = (p + PRIME < strobeEdges.size()) ? strobeEdges[p+PRIME] + LATENCY : -1;
      vectors++;
      if (pulseEdges[p] != expEdge) begin miscompares++; $display("[TB] FAIL reload_latency[%0d]: got edge %0d, expected %0d", p, pulseEdges[p], expEdge); end
      vectors++;
      if (pulseI[p] !== expI || pulseQ[p] !== expQ) begin
        miscompares++; $display("[TB] FAIL reload_data[%0d]: got %h/%h, expected %h/%h", p, pulseI[p], pulseQ[p], expI, expQ);
      end
    end
  endtask

  task automatic test_saturation();
    logic [OW-1:0] expI, expQ;
    expI = pack2(8388607, 8388607);
    expQ = pack2(-8388608, -8388608);
    setData(32767, -32768, 32767, -32768);
    loadRate(8, 0);
    clearCapture();
    for (int i = 0; i < 48; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);
    vectors++;
    if (pulseEdges.size() != 3) begin miscompares++; $display("[TB] FAIL sat_count: got %0d pulses, expected 3", pulseEdges.size()); end
    foreach (pulseEdges[p]) begin
      vectors++;
      if (pulseI[p] !== expI || pulseQ[p] !== expQ) begin
        miscompares++; $display("[TB] FAIL sat_data[%0d]: got %h/%h, expected %h/%h", p, pulseI[p], pulseQ[p], expI, expQ);
      end
    end
  endtask

  task automatic test_rounding();
    logic [OW-1:0] expI, expQ;
`ifdef CIC_DECIM_ROUND_EN
    expI = pack2(501, 0);
    expQ = pack2(-500, 0);
`else
    expI = pack2(500, 0);
    expQ = pack2(-501, 0);
`endif
    setData(1001, -1001, 0, 0);
    loadRate(8, 10);
    clearCapture();
    for (int i = 0; i < 48; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);
    vectors++;
    if (pulseEdges.size() != 3) begin miscompares++; $display("[TB] FAIL round_count: got %0d pulses, expected 3", pulseEdges.size()); end
    foreach (pulseEdges[p]) begin
      vectors++;
      if (pulseI[p] !== expI || pulseQ[p] !== expQ) begin
        miscompares++; $display("[TB] FAIL round_data[%0d]: got %h/%h, expected %h/%h", p, pulseI[p], pulseQ[p], expI, expQ);
      end
    end
  endtask

  task automatic test_rate_clamp();
    logic [OW-1:0] expI, expQ;
    int expEdge;
    expI = pack2(1000, 5);
    expQ = pack2(-1000, -5);
    setData(1000, -1000, 5, -5);
    // rate 0 clamps to 1: unity gain, every accepted sample is a strobe
    loadRate(0, 0);
    clearCapture();
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
    vectors++;
    if (pulseEdges.size() != 7) begin miscompares++; $display("[TB] FAIL clamp1_count: got %0d pulses, expected 7", pulseEdges.size()); end
    foreach (pulseEdges[p]) begin
      expEdge = (p + PRIME < strobeEdges.size()) ? strobeEdges[p+PRIME] + LATENCY : -1;
      vectors++;
      if (pulseEdges[p] != expEdge) begin miscompares++; $display("[TB] FAIL clamp1_latency[%0d]: got edge %0d, expected %0d", p, pulseEdges[p], expEdge); end
      vectors++;
      if (pulseI[p] !== expI || pulseQ[p] !== expQ) begin
        miscompares++; $display("[TB] FAIL clamp1_data[%0d]: got %h/%h, expected %h/%h", p, pulseI[p], pulseQ[p], expI, expQ);
      end
    end
    // rate 1023 clamps to 512: gain 2^27, one result after the priming blocks
    loadRate(1023, 27);
    clearCapture();
    for (int i = 0; i < 2048; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);
    vectors++;
    if (pulseEdges.size() != 1) begin miscompares++; $display("[TB] FAIL clampmax_count: got %0d pulses, expected 1", pulseEdges.size()); end
    foreach (pulseEdges[p]) begin
      expEdge = (p + PRIME < strobeEdges.size()) ? strobeEdges[p+PRIME] + LATENCY : -1;
      vectors++;
      if (pulseEdges[p] != expEdge) begin miscompares++; $display("[TB] FAIL clampmax_latency[%0d]: got edge %0d, expected %0d", p, pulseEdges[p], expEdge); end
      vectors++;
      if (pulseI[p] !== expI || pulseQ[p] !== expQ) begin
        miscompares++; $display("[TB] FAIL clampmax_data[%0d]: got %h/%h, expected %h/%h", p, pulseI[p], pulseQ[p], expI, expQ);
      end
    end
  endtask

  task automatic test_reset_mid_block();
    logic [OW-1:0] expI, expQ;
    int expEdge;
    expI = pack2(1000, 0);
    expQ = pack2(-1000, 0);
    setData(1000, -1000, 0, 0);
    loadRate(8, 9);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    i_reset = 1'b1;
    tick(1'b1, 1'b0);
    i_reset = 1'b0;
    vectors++;
    if (o_valid !== 1'b0 || o_inph_data !== '0 || o_quad_data !== '0) begin
      miscompares++; $display("[TB] FAIL midreset_state: got valid %b data %h/%h, expected 0 0/0", o_valid, o_inph_data, o_quad_data);
    end
    loadRate(8, 9);
    clearCapture();
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b0);
    vectors++;
    if (pulseEdges.size() != 2) begin miscompares++; $display("[TB] FAIL midreset_count: got %0d pulses, expected 2", pulseEdges.size()); end
    foreach (pulseEdges[p]) begin
      expEdge = (p + PRIME < strobeEdges.size()) ? strobeEdges[p+PRIME] + LATENCY : -1;
      vectors++;
      if (pulseEdges[p] != expEdge) begin miscompares++; $display("[TB] FAIL midreset_latency[%0d]: got edge %0d, expected %0d", p, pulseEdges[p], expEdge); end
      vectors++;
      if (pulseI[p] !== expI || pulseQ[p] !== expQ) begin
        miscompares++; $display("[TB] FAIL midreset_data[%0d]: got %h/%h, expected %h/%h", p, pulseI[p], pulseQ[p], expI, expQ);
      end
    end
  endtask

  initial begin
    i_reset     = 1'b0;
    i_valid     = 1'b0;
    i_rate_load = 1'b0;
    i_rate      = '0;
    i_shift     = SHIFT_W'(9);
    i_inph_data = '0;
    i_quad_data = '0;
    test_reset();
    test_idle();
    test_dc_gain();
    test_rate_reload();
    test_saturation();
    test_rounding();
    test_rate_clamp();
    test_reset_mid_block();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
